// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for 8 requesters. It drives a registered one-hot grant and enable into a downstream 8-to-3 encoder.
// A hold limit revokes any grant that stays high for MAX_HOLD cycles, and each release is followed by one dead cycle.
module rr_onehot_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic       en,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q;
  logic [2:0]        ptr_q;
  logic [2:0]        gidx_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;
  logic [7:0]        grant_q;
  logic              en_q;
  logic              timeout_q;

  logic              sel_vld;
  logic [2:0]        sel_idx;
  logic [2:0]        scan_idx;

  // Walk from the farthest offset back to ptr, so the nearest set bit at or after ptr wins.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      scan_idx = ptr_q + 3'(k);
      if (req[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (sel_vld) begin
            grant_q <= 8'b1 << sel_idx;
            en_q    <= 1'b1;
            gidx_q  <= sel_idx;
            cnt_q   <= '0;
            state_q <= GRANT;
          end else begin
            grant_q <= '0;
            en_q    <= 1'b0;
          end
        end
        GRANT: begin
          if (done || !req[gidx_q] || cnt_q == HOLD_LAST) begin
            // A release caused by done or a dropped request takes precedence over the hold limit.
            timeout_q <= !(done || !req[gidx_q]);
            grant_q   <= '0;
            en_q      <= 1'b0;
            ptr_q     <= gidx_q + 3'd1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign en      = en_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter with MAX_HOLD=16. It uses a vector table plus hand-written hold-limit and reset sequences.
// Expected outputs are queued when inputs are driven and compared one cycle later, and the invariants are checked every cycle.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       en;
  logic       timeout;

  rr_onehot_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .en      (en),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic       e;
    logic       t;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] g;
    logic       e;
    logic       t;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   vec_id  = 0;
  bit   started = 0;
  logic prev_to = 1'b0;

  task automatic add(input logic r, input logic [7:0] rq, input logic d,
                     input logic [7:0] g, input logic e, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.g = g; v.e = e; v.t = t;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [7:0] rq, input logic d,
                       input logic [7:0] g, input logic e, input logic t);
    exp_t x;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    x.id = vec_id; x.g = g; x.e = e; x.t = t;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Monitor: pops one expectation per edge and checks the output invariants.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      started = 1;
      n_cmp++;
      if (grant !== x.g || en !== x.e || timeout !== x.t) begin
        n_fail++;
        $display("FAIL vec%0d grant/en/timeout got %h/%b/%b want %h/%b/%b",
                 x.id, grant, en, timeout, x.g, x.e, x.t);
      end
    end
    if (started) begin
      n_cmp++;
      if (!$onehot0(grant) || en !== (|grant) || (timeout && grant != 0) || (timeout && prev_to)) begin
        n_fail++;
        $display("FAIL invariant grant=%h en=%b timeout=%b prev_timeout=%b (want onehot0, en=|grant, no timeout with grant or twice)",
                 grant, en, timeout, prev_to);
      end
      prev_to = timeout;
    end
  end

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;

    // Reset, then 0x81 round robin with done three cycles into each grant.
    add(1, 8'hFF, 0, 8'h00, 0, 0);
    add(1, 8'hFF, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, 8'h01, 1, 0);
    add(0, 8'h81, 0, 8'h01, 1, 0);
    add(0, 8'h81, 0, 8'h01, 1, 0);
    add(0, 8'h81, 1, 8'h00, 0, 0);
    add(0, 8'h81, 0, 8'h80, 1, 0);
    add(0, 8'h81, 0, 8'h80, 1, 0);
    add(0, 8'h81, 0, 8'h80, 1, 0);
    add(0, 8'h81, 1, 8'h00, 0, 0);
    add(0, 8'h81, 0, 8'h01, 1, 0);
    add(0, 8'h81, 0, 8'h01, 1, 0);
    add(0, 8'h81, 0, 8'h01, 1, 0);
    add(0, 8'h81, 1, 8'h00, 0, 0);
    // Grant 0x10, then the request drops and the arbiter stays idle.
    add(0, 8'h10, 0, 8'h10, 1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0);
    // Grant 0x40 so that ptr becomes 7, then 0x41 wraps to bit 0 before bit 6.
    add(0, 8'h40, 0, 8'h40, 1, 0);
    add(0, 8'h40, 1, 8'h00, 0, 0);
    add(0, 8'h41, 0, 8'h01, 1, 0);
    add(0, 8'h41, 1, 8'h00, 0, 0);
    add(0, 8'h41, 0, 8'h40, 1, 0);
    add(0, 8'h41, 1, 8'h00, 0, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0);

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].g, tbl[i].e, tbl[i].t);

    // Hold limit: 16 cycles of 0x04, one timeout cycle, then 0x04 is granted again.
    for (int i = 0; i < 16; i++) drive(0, 8'h04, 0, 8'h04, 1, 0);
    drive(0, 8'h04, 0, 8'h00, 0, 1);
    drive(0, 8'h04, 0, 8'h04, 1, 0);
    // done arrives on the limit cycle, so this is a normal release without timeout.
    for (int i = 0; i < 15; i++) drive(0, 8'h04, 0, 8'h04, 1, 0);
    drive(0, 8'h04, 1, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 0, 0);

    // Reset mid-grant drops the grant at that edge and ptr returns to 0.
    drive(0, 8'h08, 0, 8'h08, 1, 0);
    drive(0, 8'h08, 0, 8'h08, 1, 0);
    drive(1, 8'h08, 0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 0, 0);
    drive(0, 8'hFF, 0, 8'h01, 1, 0);
    drive(0, 8'hFF, 1, 8'h00, 0, 0);
    drive(0, 8'hFF, 0, 8'h02, 1, 0);

    @(negedge clk);
    req = 8'h00; done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
